// File: rtl/uart_tx_fifo.sv
// UART transmitter: a word FIFO feeding a start/data/parity/stop serialiser.
// One frame bit per Clk period; CTS is sampled only when a frame is about to start.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_BIT = 1,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Write,
  input  logic                 CTS,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 Tx_Done,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow
);

  localparam int unsigned TX_BITS = 1 + DATA_BITS + PARITY_BIT + STOP_BITS;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned IW      = $clog2(TX_BITS);

  localparam logic [AW:0]   DepthCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] LastData = IW'(DATA_BITS);
  localparam logic [IW-1:0] LastBit  = IW'(TX_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  assign FIFO_Empty    = (count_q == '0);
  assign FIFO_Full     = (count_q == DepthCnt);
  assign FIFO_Overflow = ovf_q;
  assign Tx            = tx_q;
  assign Tx_Done       = done_q;
  assign Tx_Busy       = (state_q != StIdle);

  // A pop frees a slot in the same cycle, so a write into a full FIFO can still land.
  assign push = Write && (!FIFO_Full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_q] <= Tx_Data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      if (Write && !push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // idx_q is the position within the frame of the bit currently driven on Tx.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q + IW'(1);
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = 1'b1;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
      end
      StStart: begin
        state_d = StData;
        tx_d    = shift_q[DATA_BITS-1];
        shift_d = shift_q << 1;
      end
      StData: begin
        if (idx_q == LastData) begin
          if (PARITY_BIT != 0) begin
            state_d = StParity;
            tx_d    = parity_q;
          end else begin
            state_d = StStop;
          end
        end else begin
          tx_d    = shift_q[DATA_BITS-1];
          shift_d = shift_q << 1;
        end
      end
      StParity: begin
        state_d = StStop;
      end
      StStop: begin
        if (idx_q == LastBit) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase

    // Frame start uses the registered count, so a word is never sent in its own write cycle.
    if ((state_q == StIdle || (state_q == StStop && idx_q == LastBit)) &&
        count_q != '0 && CTS) begin
      pop      = 1'b1;
      state_d  = StStart;
      idx_d    = '0;
      tx_d     = 1'b0;
      shift_d  = mem[rd_ptr_q];
      parity_d = ^mem[rd_ptr_q];
    end
  end

  assign done_d = (state_d == StStop) && (idx_d == LastBit);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame scenarios plus random traffic,
// all compared against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int NBITS = 12;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Write = 1'b0;
  logic          CTS = 1'b0;
  logic [DW-1:0] Tx_Data = '0;
  logic          Tx, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow;

  int checks = 0;
  int errors = 0;
  logic [5:0] obs;

  // Reference model: pending words plus the remaining bits of the frame on the line.
  logic [DW-1:0] m_fifo[$];
  logic          m_frame[$];
  logic          m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  uart_tx_fifo #(
    .DATA_BITS (DW),
    .PARITY_BIT(1),
    .STOP_BITS (2),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Tx_Data      (Tx_Data),
    .Write        (Write),
    .CTS          (CTS),
    .Tx           (Tx),
    .Tx_Busy      (Tx_Busy),
    .Tx_Done      (Tx_Done),
    .FIFO_Empty   (FIFO_Empty),
    .FIFO_Full    (FIFO_Full),
    .FIFO_Overflow(FIFO_Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic model_step();
    int sz;
    logic popped;
    logic [DW-1:0] w;
    if (!Rst) begin
      m_fifo.delete();
      m_frame.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      sz = m_fifo.size();
      popped = 1'b0;
      m_done = 1'b0;
      if (m_busy && m_frame.size() > 0) begin
        m_tx = m_frame.pop_front();
        m_done = (m_frame.size() == 0);
      end else if (sz > 0 && CTS) begin
        w = m_fifo.pop_front();
        popped = 1'b1;
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int b = DW - 1; b >= 0; b--) m_frame.push_back(w[b]);
        m_frame.push_back(^w);
        m_frame.push_back(1'b1);
        m_frame.push_back(1'b1);
        m_tx = m_frame.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_busy = 1'b0;
      end
      if (Write) begin
        if (sz < DEPTH || popped) m_fifo.push_back(Tx_Data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [5:0] exp_vec();
    return {m_tx, m_busy, m_done, m_fifo.size() == 0, m_fifo.size() == DEPTH, m_ovf};
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    obs = {Tx, Tx_Busy, Tx_Done, FIFO_Empty, FIFO_Full, FIFO_Overflow};
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; Write = 1'b0; CTS = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b0; Write = 1'b1; CTS = 1'b1; Tx_Data = 8'h5A;
    tick();
    checks++;
    if (obs !== 6'b100100) begin
      errors++; $display("FAIL reset_values: got %b want %b", obs, 6'b100100);
    end
    @(negedge Clk);
    Rst = 1'b1; Write = 1'b0; CTS = 1'b0;
    tick();
    checks++;
    if (obs !== exp_vec() || obs !== 6'b100100) begin
      errors++; $display("FAIL reset_write_ignored: got %b want %b", obs, 6'b100100);
    end
  endtask

  task automatic test_frame(input logic [DW-1:0] w, input logic [NBITS-1:0] want,
                            input string tag);
    logic [NBITS-1:0] got;
    int busy_n, done_n, done_at;
    do_reset();
    CTS = 1'b1; Write = 1'b1; Tx_Data = w;
    tick();
    checks++;
    if (FIFO_Empty !== 1'b0 || Tx !== 1'b1 || Tx_Busy !== 1'b0) begin
      errors++; $display("FAIL %s_latency: empty=%b tx=%b busy=%b want 0 1 0",
                         tag, FIFO_Empty, Tx, Tx_Busy);
    end
    @(negedge Clk);
    Write = 1'b0;
    got = '0; busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < NBITS; i++) begin
      tick();
      got[NBITS-1-i] = Tx;
      busy_n += int'(Tx_Busy);
      if (Tx_Done) begin done_n++; done_at = i; end
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL %s_model cyc %0d: got %b want %b", tag, i, obs, exp_vec());
      end
    end
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s_bits: got %b want %b", tag, got, want);
    end
    checks++;
    if (busy_n != NBITS || done_n != 1 || done_at != NBITS - 1) begin
      errors++; $display("FAIL %s_busy_done: busy=%0d done=%0d at %0d want 12 1 at 11",
                         tag, busy_n, done_n, done_at);
    end
    tick();
    checks++;
    if (Tx_Busy !== 1'b0 || Tx !== 1'b1 || FIFO_Empty !== 1'b1) begin
      errors++; $display("FAIL %s_idle: busy=%b tx=%b empty=%b want 0 1 1",
                         tag, Tx_Busy, Tx, FIFO_Empty);
    end
  endtask

  task automatic test_fill_overflow();
    logic line [0:8*NBITS-1];
    logic [DW-1:0] word;
    int not_busy;
    do_reset();
    CTS = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      Write = 1'b1; Tx_Data = DW'(i);
      tick();
      @(negedge Clk);
    end
    checks++;
    if (FIFO_Full !== 1'b1 || Tx !== 1'b1 || Tx_Busy !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b tx=%b busy=%b want 1 1 0",
                         FIFO_Full, Tx, Tx_Busy);
    end
    Tx_Data = 8'hFF;
    tick();
    checks++;
    if (FIFO_Overflow !== 1'b1 || FIFO_Full !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL overflow_set: got %b want %b", obs, exp_vec());
    end
    @(negedge Clk);
    Write = 1'b0; CTS = 1'b1;
    not_busy = 0;
    for (int i = 0; i < 8 * NBITS; i++) begin
      tick();
      line[i] = Tx;
      if (!Tx_Busy) not_busy++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL drain_model cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    checks++;
    if (not_busy != 0) begin
      errors++; $display("FAIL drain_contiguous: idle cycles %0d want 0", not_busy);
    end
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < DW; b++) word[DW-1-b] = line[f*NBITS+1+b];
      checks++;
      if (word !== DW'(f)) begin
        errors++; $display("FAIL drain_frame %0d: got %h want %h", f, word, f);
      end
    end
    tick();
    checks++;
    if (FIFO_Empty !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Overflow !== 1'b1) begin
      errors++; $display("FAIL drain_end: empty=%b busy=%b ovf=%b want 1 0 1",
                         FIFO_Empty, Tx_Busy, FIFO_Overflow);
    end
  endtask

  task automatic test_cts_drop();
    logic [NBITS-1:0] got;
    int bad;
    do_reset();
    CTS = 1'b1; Write = 1'b1; Tx_Data = 8'h3C;
    tick();
    @(negedge Clk);
    Tx_Data = 8'h11;
    for (int i = 0; i < NBITS; i++) begin
      tick();
      got[NBITS-1-i] = Tx;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL cts_model cyc %0d: got %b want %b", i, obs, exp_vec());
      end
      @(negedge Clk);
      Write = 1'b0;
      if (i == 4) CTS = 1'b0;
    end
    checks++;
    if (got !== 12'b000111100011) begin
      errors++; $display("FAIL cts_first_frame: got %b want %b", got, 12'b000111100011);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || obs !== exp_vec()) bad++;
      @(negedge Clk);
    end
    checks++;
    if (bad != 0 || FIFO_Empty !== 1'b0) begin
      errors++; $display("FAIL cts_held: bad cycles %0d empty=%b want 0 0", bad, FIFO_Empty);
    end
    CTS = 1'b1;
    tick();
    checks++;
    if (Tx !== 1'b0 || Tx_Busy !== 1'b1) begin
      errors++; $display("FAIL cts_resume_start: tx=%b busy=%b want 0 1", Tx, Tx_Busy);
    end
    for (int i = 1; i < NBITS + 1; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL cts_second cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_full_simul();
    logic line [0:9*NBITS-1];
    logic [DW-1:0] words [9];
    logic [DW-1:0] word;
    do_reset();
    CTS = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = DW'($urandom);
      Write = 1'b1; Tx_Data = words[i];
      tick();
      @(negedge Clk);
    end
    words[8] = 8'h55;
    CTS = 1'b1; Tx_Data = 8'h55;
    tick();
    line[0] = Tx;
    checks++;
    if (FIFO_Overflow !== 1'b0 || FIFO_Full !== 1'b1 || Tx !== 1'b0) begin
      errors++; $display("FAIL simul_accept: ovf=%b full=%b tx=%b want 0 1 0",
                         FIFO_Overflow, FIFO_Full, Tx);
    end
    @(negedge Clk);
    Write = 1'b0;
    for (int i = 1; i < 9 * NBITS; i++) begin
      tick();
      line[i] = Tx;
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL simul_model cyc %0d: got %b want %b", i, obs, exp_vec());
      end
    end
    for (int f = 0; f < 9; f++) begin
      for (int b = 0; b < DW; b++) word[DW-1-b] = line[f*NBITS+1+b];
      checks++;
      if (word !== words[f]) begin
        errors++; $display("FAIL simul_frame %0d: got %h want %h", f, word, words[f]);
      end
    end
    checks++;
    if (FIFO_Overflow !== 1'b0 || FIFO_Empty !== 1'b1) begin
      errors++; $display("FAIL simul_end: ovf=%b empty=%b want 0 1", FIFO_Overflow, FIFO_Empty);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    CTS = 1'b1; Write = 1'b1; Tx_Data = 8'hF0;
    tick();
    @(negedge Clk);
    Write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge Clk);
    end
    checks++;
    if (Tx_Busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: busy=%b want 1", Tx_Busy);
    end
    Rst = 1'b0;
    tick();
    checks++;
    if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || FIFO_Empty !== 1'b1) begin
      errors++; $display("FAIL midreset_abort: tx=%b busy=%b empty=%b want 1 0 1",
                         Tx, Tx_Busy, FIFO_Empty);
    end
    @(negedge Clk);
    Rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || obs !== exp_vec()) bad++;
      @(negedge Clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset_residual: bad cycles %0d want 0", bad);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      Write = ($urandom_range(0, 99) < 45);
      Tx_Data = DW'($urandom);
      if ($urandom_range(0, 99) < 8) CTS = ~CTS;
      Rst = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d: got %b want %b", i, obs, exp_vec());
      end
      @(negedge Clk);
    end
    Rst = 1'b1; Write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5, 12'b010100101011, "frame_a5");
    test_frame(8'h01, 12'b000000001111, "frame_01");
    test_fill_overflow();
    test_cts_drop();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
